// File: rtl/flush_sequencer_pkg.sv
// Shared types and default sizes for the flush recovery sequencer.
package flush_sequencer_pkg;

  localparam int unsigned FSEQ_PC_BITS        = 32;
  localparam int unsigned FSEQ_ROB_INDEX_BITS = 3;
  localparam int unsigned FSEQ_MAX_BRANCH_IF  = 2;
  localparam int unsigned FSEQ_RAT_ID_BITS    = $clog2(FSEQ_MAX_BRANCH_IF);
  localparam int unsigned FSEQ_CNT_BITS       = 16;

  typedef enum logic [1:0] {
    IDLE,
    SQUASH,
    REDIRECT
  } fseq_state_t;

  typedef struct packed {
    logic [FSEQ_PC_BITS-1:0]        pc;
    logic [FSEQ_ROB_INDEX_BITS-1:0] ticket;
    logic [FSEQ_RAT_ID_BITS-1:0]    rat_id;
  } flush_cmd_t;

endpackage

// File: rtl/flush_sequencer_if.sv
// Flush command, ROB squash, RAT restore and fetch redirect handshakes.
// master is the sequencer side; slave is the surrounding pipeline.
interface flush_sequencer_if
  import flush_sequencer_pkg::*;
#(
  parameter int unsigned PC_BITS        = FSEQ_PC_BITS,
  parameter int unsigned ROB_INDEX_BITS = FSEQ_ROB_INDEX_BITS,
  parameter int unsigned MAX_BRANCH_IF  = FSEQ_MAX_BRANCH_IF
);
  localparam int unsigned RAT_ID_BITS = $clog2(MAX_BRANCH_IF);

  logic                      flush_valid;
  logic [PC_BITS-1:0]        flush_pc;
  logic [ROB_INDEX_BITS-1:0] flush_ticket;
  logic [RAT_ID_BITS-1:0]    flush_rat_id;
  logic [ROB_INDEX_BITS-1:0] rob_head;

  logic                      rob_squash_valid;
  logic [ROB_INDEX_BITS-1:0] rob_squash_ticket;
  logic                      rob_squash_ack;

  logic                      rat_restore_valid;
  logic [RAT_ID_BITS-1:0]    rat_restore_id;
  logic                      rat_restore_ack;

  logic                      redirect_valid;
  logic [PC_BITS-1:0]        redirect_pc;
  logic                      redirect_ready;

  modport master (
    input  flush_valid, flush_pc, flush_ticket, flush_rat_id, rob_head,
    input  rob_squash_ack, rat_restore_ack, redirect_ready,
    output rob_squash_valid, rob_squash_ticket,
    output rat_restore_valid, rat_restore_id,
    output redirect_valid, redirect_pc
  );

  modport slave (
    output flush_valid, flush_pc, flush_ticket, flush_rat_id, rob_head,
    output rob_squash_ack, rat_restore_ack, redirect_ready,
    input  rob_squash_valid, rob_squash_ticket,
    input  rat_restore_valid, rat_restore_id,
    input  redirect_valid, redirect_pc
  );

endinterface

// File: rtl/rob_age_compare.sv
// Ticket age comparison relative to the ROB head; older = ticket_a strictly
// older than ticket_b. Ages wrap modulo 2^TICKET_BITS.
module rob_age_compare #(
  parameter int unsigned TICKET_BITS = 3
) (
  input  logic [TICKET_BITS-1:0] ticket_a,
  input  logic [TICKET_BITS-1:0] ticket_b,
  input  logic [TICKET_BITS-1:0] head,
  output logic                   older
);

  logic [TICKET_BITS-1:0] age_a;
  logic [TICKET_BITS-1:0] age_b;

  always_comb begin
    age_a = ticket_a - head;
    age_b = ticket_b - head;
    older = age_a < age_b;
  end

endmodule

// File: rtl/flush_sequencer.sv
// Runs ROB squash + RAT restore, then fetch redirect, for each accepted flush.
// Older flushes restart the sequence; equal/younger ones are dropped.
module flush_sequencer
  import flush_sequencer_pkg::*;
#(
  parameter int unsigned PC_BITS        = FSEQ_PC_BITS,
  parameter int unsigned ROB_INDEX_BITS = FSEQ_ROB_INDEX_BITS,
  parameter int unsigned MAX_BRANCH_IF  = FSEQ_MAX_BRANCH_IF,
  parameter int unsigned CNT_BITS       = FSEQ_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  flush_sequencer_if.master   bus,
  output logic                frontend_flush,
  output logic                busy,
  output logic [CNT_BITS-1:0] flush_count,
  output logic [CNT_BITS-1:0] recovery_cycles
);

  localparam int unsigned RAT_ID_BITS = $clog2(MAX_BRANCH_IF);

  fseq_state_t state_q, state_n;
  flush_cmd_t  cmd_q, cmd_n;
  logic        rob_done_q, rob_done_n;
  logic        rat_done_q, rat_done_n;
  logic        older;
  logic        accept;

  logic [PC_BITS-1:0]        redirect_pc_n;
  logic [ROB_INDEX_BITS-1:0] squash_ticket_n;
  logic [RAT_ID_BITS-1:0]    restore_id_n;

  rob_age_compare #(
    .TICKET_BITS(ROB_INDEX_BITS)
  ) u_age (
    .ticket_a(bus.flush_ticket),
    .ticket_b(cmd_q.ticket),
    .head    (bus.rob_head),
    .older   (older)
  );

  // An accepted flush takes priority over any ack or redirect handshake
  // seen in the same cycle; those are simply discarded.
  always_comb begin
    state_n    = state_q;
    cmd_n      = cmd_q;
    rob_done_n = rob_done_q;
    rat_done_n = rat_done_q;
    accept     = bus.flush_valid && ((state_q == IDLE) || older);
    if (accept) begin
      state_n       = SQUASH;
      cmd_n.pc      = bus.flush_pc;
      cmd_n.ticket  = bus.flush_ticket;
      cmd_n.rat_id  = bus.flush_rat_id;
      rob_done_n    = 1'b0;
      rat_done_n    = 1'b0;
    end else begin
      unique case (state_q)
        SQUASH: begin
          if (!rob_done_q && bus.rob_squash_ack)  rob_done_n = 1'b1;
          if (!rat_done_q && bus.rat_restore_ack) rat_done_n = 1'b1;
          if (rob_done_n && rat_done_n)           state_n    = REDIRECT;
        end
        REDIRECT: begin
          if (bus.redirect_ready) state_n = IDLE;
        end
        default: ;
      endcase
    end
    redirect_pc_n   = cmd_n.pc;
    squash_ticket_n = cmd_n.ticket;
    restore_id_n    = cmd_n.rat_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      cmd_q                 <= '0;
      rob_done_q            <= 1'b0;
      rat_done_q            <= 1'b0;
      frontend_flush        <= 1'b0;
      busy                  <= 1'b0;
      flush_count           <= '0;
      recovery_cycles       <= '0;
      bus.rob_squash_valid  <= 1'b0;
      bus.rob_squash_ticket <= '0;
      bus.rat_restore_valid <= 1'b0;
      bus.rat_restore_id    <= '0;
      bus.redirect_valid    <= 1'b0;
      bus.redirect_pc       <= '0;
    end else begin
      state_q               <= state_n;
      cmd_q                 <= cmd_n;
      rob_done_q            <= rob_done_n;
      rat_done_q            <= rat_done_n;
      frontend_flush        <= accept;
      busy                  <= (state_n != IDLE);
      bus.rob_squash_valid  <= (state_n == SQUASH) && !rob_done_n;
      bus.rat_restore_valid <= (state_n == SQUASH) && !rat_done_n;
      bus.redirect_valid    <= (state_n == REDIRECT);
      bus.rob_squash_ticket <= squash_ticket_n;
      bus.rat_restore_id    <= restore_id_n;
      bus.redirect_pc       <= redirect_pc_n;
      if (accept && !(&flush_count))        flush_count     <= flush_count + 1'b1;
      if (busy && !(&recovery_cycles))      recovery_cycles <= recovery_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: basic flow, staggered acks, overrides,
// wrap-around age, redirect collision, reset mid-recovery and saturation.
module tb_flush_sequencer;
  import flush_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        frontend_flush;
  logic        busy;
  logic [15:0] flush_count;
  logic [15:0] recovery_cycles;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  flush_sequencer_if #(
    .PC_BITS(32),
    .ROB_INDEX_BITS(3),
    .MAX_BRANCH_IF(2)
  ) bus ();

  flush_sequencer #(
    .PC_BITS(32),
    .ROB_INDEX_BITS(3),
    .MAX_BRANCH_IF(2),
    .CNT_BITS(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .frontend_flush (frontend_flush),
    .busy           (busy),
    .flush_count    (flush_count),
    .recovery_cycles(recovery_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_valid     = 1'b0;
    bus.flush_pc        = '0;
    bus.flush_ticket    = '0;
    bus.flush_rat_id    = '0;
    bus.rob_squash_ack  = 1'b0;
    bus.rat_restore_ack = 1'b0;
    bus.redirect_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_flush(input logic [31:0] pc, input logic [2:0] ticket, input logic rat);
    bus.flush_valid  = 1'b1;
    bus.flush_pc     = pc;
    bus.flush_ticket = ticket;
    bus.flush_rat_id = rat;
  endtask

  task automatic send_flush(input logic [31:0] pc, input logic [2:0] ticket, input logic rat);
    drive_flush(pc, ticket, rat);
    step();
    bus.flush_valid = 1'b0;
  endtask

  task automatic both_acks();
    bus.rob_squash_ack  = 1'b1;
    bus.rat_restore_ack = 1'b1;
    step();
    bus.rob_squash_ack  = 1'b0;
    bus.rat_restore_ack = 1'b0;
  endtask

  task automatic ready_pulse();
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
  endtask

  // Flush at cycle 0, acks in cycle 2, redirect_ready in cycle 4; counters start at 0.
  task automatic run_basic(input string tag, input logic [31:0] pc, input logic [2:0] ticket,
                           input logic rat);
    send_flush(pc, ticket, rat);
    check({tag, ".ff_pulse"}, frontend_flush, 1);
    check({tag, ".busy1"}, busy, 1);
    check({tag, ".rob_v"}, bus.rob_squash_valid, 1);
    check({tag, ".rat_v"}, bus.rat_restore_valid, 1);
    check({tag, ".ticket"}, bus.rob_squash_ticket, ticket);
    check({tag, ".rat_id"}, bus.rat_restore_id, rat);
    check({tag, ".fcount1"}, flush_count, 1);
    step();
    check({tag, ".ff_drop"}, frontend_flush, 0);
    check({tag, ".busy2"}, busy, 1);
    both_acks();
    check({tag, ".rob_v_drop"}, bus.rob_squash_valid, 0);
    check({tag, ".rat_v_drop"}, bus.rat_restore_valid, 0);
    check({tag, ".redir_v"}, bus.redirect_valid, 1);
    check({tag, ".redir_pc"}, bus.redirect_pc, pc);
    step();
    check({tag, ".redir_hold"}, bus.redirect_valid, 1);
    ready_pulse();
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".redir_end"}, bus.redirect_valid, 0);
    check({tag, ".rcycles"}, recovery_cycles, 4);
    check({tag, ".fcount_end"}, flush_count, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".ff"}, frontend_flush, 0);
    check({tag, ".rob_v"}, bus.rob_squash_valid, 0);
    check({tag, ".rat_v"}, bus.rat_restore_valid, 0);
    check({tag, ".redir_v"}, bus.redirect_valid, 0);
    check({tag, ".redir_pc"}, bus.redirect_pc, 0);
    check({tag, ".ticket"}, bus.rob_squash_ticket, 0);
    check({tag, ".rat_id"}, bus.rat_restore_id, 0);
    check({tag, ".fcount"}, flush_count, 0);
    check({tag, ".rcycles"}, recovery_cycles, 0);
  endtask

  initial begin
    bus.rob_head = '0;
    do_reset();
    check_all_zero("reset");

    // Basic sequence
    run_basic("basic", 32'h100, 3'd2, 1'b1);

    // Staggered acks: rob at cycle 1, rat at cycle 4
    do_reset();
    send_flush(32'h180, 3'd3, 1'b0);
    bus.rob_squash_ack = 1'b1;
    step();
    bus.rob_squash_ack = 1'b0;
    check("stag.rob_v_drop", bus.rob_squash_valid, 0);
    check("stag.rat_v_hold", bus.rat_restore_valid, 1);
    check("stag.no_redir", bus.redirect_valid, 0);
    step();
    step();
    check("stag.rat_v_hold2", bus.rat_restore_valid, 1);
    check("stag.no_redir2", bus.redirect_valid, 0);
    bus.rat_restore_ack = 1'b1;
    step();
    bus.rat_restore_ack = 1'b0;
    check("stag.redir_v", bus.redirect_valid, 1);
    check("stag.rat_v_drop", bus.rat_restore_valid, 0);
    ready_pulse();
    check("stag.busy_end", busy, 0);
    check("stag.rcycles", recovery_cycles, 5);

    // Older override in SQUASH with a same-cycle rob ack (ack discarded)
    do_reset();
    bus.rob_head = 3'd6;
    send_flush(32'h200, 3'd1, 1'b0);
    drive_flush(32'h300, 3'd7, 1'b1);
    bus.rob_squash_ack = 1'b1;
    step();
    idle_inputs();
    check("ovr.ticket", bus.rob_squash_ticket, 7);
    check("ovr.fcount", flush_count, 2);
    check("ovr.ff", frontend_flush, 1);
    check("ovr.rob_v_restart", bus.rob_squash_valid, 1);
    check("ovr.rat_id", bus.rat_restore_id, 1);
    both_acks();
    check("ovr.redir_pc", bus.redirect_pc, 32'h300);

    // Younger and equal tickets in SQUASH are ignored
    do_reset();
    bus.rob_head = 3'd6;
    send_flush(32'h200, 3'd1, 1'b0);
    send_flush(32'h300, 3'd2, 1'b1);
    check("young.ticket", bus.rob_squash_ticket, 1);
    check("young.fcount", flush_count, 1);
    check("young.ff", frontend_flush, 0);
    check("young.busy", busy, 1);
    send_flush(32'h340, 3'd1, 1'b1);
    check("equal.fcount", flush_count, 1);
    check("equal.rat_id", bus.rat_restore_id, 0);

    // Wrap-around age, override while in REDIRECT
    do_reset();
    bus.rob_head = 3'd5;
    send_flush(32'h400, 3'd0, 1'b0);
    both_acks();
    check("wrap.redir_v", bus.redirect_valid, 1);
    send_flush(32'h480, 3'd6, 1'b1);
    check("wrap.redir_drop", bus.redirect_valid, 0);
    check("wrap.rob_v", bus.rob_squash_valid, 1);
    check("wrap.ticket", bus.rob_squash_ticket, 6);
    check("wrap.ff", frontend_flush, 1);
    check("wrap.fcount", flush_count, 2);

    // Redirect handshake colliding with an older flush: override wins
    do_reset();
    bus.rob_head = 3'd0;
    send_flush(32'h500, 3'd4, 1'b0);
    both_acks();
    drive_flush(32'h580, 3'd1, 1'b1);
    bus.redirect_ready = 1'b1;
    step();
    idle_inputs();
    check("coll.redir_v", bus.redirect_valid, 0);
    check("coll.ff", frontend_flush, 1);
    check("coll.busy", busy, 1);
    check("coll.rob_v", bus.rob_squash_valid, 1);
    check("coll.ticket", bus.rob_squash_ticket, 1);
    check("coll.fcount", flush_count, 2);
    both_acks();
    check("coll.redir_pc", bus.redirect_pc, 32'h580);
    // Younger flush on the handshake cycle is ignored
    drive_flush(32'h5c0, 3'd3, 1'b0);
    bus.redirect_ready = 1'b1;
    step();
    idle_inputs();
    check("coll_y.busy", busy, 0);
    check("coll_y.redir_v", bus.redirect_valid, 0);
    check("coll_y.ff", frontend_flush, 0);
    check("coll_y.fcount", flush_count, 2);

    // Reset mid-recovery after rob ack, then a fresh full sequence
    do_reset();
    send_flush(32'h600, 3'd2, 1'b1);
    bus.rob_squash_ack = 1'b1;
    step();
    bus.rob_squash_ack = 1'b0;
    check("rstmid.rob_v", bus.rob_squash_valid, 0);
    do_reset();
    check_all_zero("rstmid");
    run_basic("fresh", 32'h700, 3'd5, 1'b0);

    // Saturation of recovery_cycles
    do_reset();
    send_flush(32'h800, 3'd1, 1'b0);
    for (int i = 0; i < 65540; i++) step();
    check("sat.rcycles", recovery_cycles, 16'hFFFF);
    step();
    check("sat.rcycles_hold", recovery_cycles, 16'hFFFF);
    check("sat.fcount", flush_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
